// File: rtl/encryptfsm.sv
// AES-128 forward-direction control sequencer: initial AddRoundKey plus ten rounds, one per clock.
// Optional ENCRYPTFSM_B2B_EN lets a start in ROUND10 chain straight into the next block.
module encryptfsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       staenc,
  output logic [1:0] keysel,
  output logic       rndkren,
  output logic [3:0] rconsel,
  output logic       sboxinsel,
  output logic       wrregen,
  output logic [1:0] keyadsel,
  output logic       mixsel,
  output logic       reginsel,
  output logic [3:0] enc_state,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    IDLE            = 4'd0,
    INITIAL_KEY_ADD = 4'd1,
    ROUND1          = 4'd2,
    ROUND2          = 4'd3,
    ROUND3          = 4'd4,
    ROUND4          = 4'd5,
    ROUND5          = 4'd6,
    ROUND6          = 4'd7,
    ROUND7          = 4'd8,
    ROUND8          = 4'd9,
    ROUND9          = 4'd10,
    ROUND10         = 4'd11
  } state_t;

  state_t     state, state_nxt;
  logic       done_nxt;
  logic [3:0] code;

  assign code = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    done_nxt  = 1'b0;
    case (state)
      IDLE:
        state_nxt = staenc ? INITIAL_KEY_ADD : IDLE;
      INITIAL_KEY_ADD, ROUND1, ROUND2, ROUND3, ROUND4,
      ROUND5, ROUND6, ROUND7, ROUND8, ROUND9:
        state_nxt = state_t'(code + 4'd1);
      ROUND10: begin
        done_nxt = 1'b1;
`ifdef ENCRYPTFSM_B2B_EN
        state_nxt = staenc ? INITIAL_KEY_ADD : IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      default:
        state_nxt = IDLE; // codes 12..15 recover without a done pulse
    endcase
  end

  // Datapath decode; unlisted (illegal) codes fall through to the IDLE values.
  always_comb begin
    keysel   = 2'd0;
    rndkren  = 1'b0;
    rconsel  = 4'd0;
    wrregen  = 1'b0;
    keyadsel = 2'd0;
    reginsel = 1'b0;
    case (state)
      INITIAL_KEY_ADD: begin
        rndkren  = 1'b1;
        wrregen  = 1'b1;
        keyadsel = 2'd1;
      end
      ROUND1, ROUND2, ROUND3, ROUND4, ROUND5,
      ROUND6, ROUND7, ROUND8, ROUND9: begin
        keysel   = 2'd2;
        rndkren  = 1'b1;
        rconsel  = code - 4'd2;
        wrregen  = 1'b1;
        reginsel = 1'b1;
      end
      ROUND10: begin
        keysel   = 2'd2;
        rconsel  = 4'd9;
        wrregen  = 1'b1;
        keyadsel = 2'd2;
        reginsel = 1'b1;
      end
      default: ;
    endcase
  end

  assign sboxinsel = 1'b0;
  assign mixsel    = 1'b0;
  assign enc_state = code;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_encryptfsm.sv
// Scoreboard bench for encryptfsm: stimulus pushes hand-derived per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_encryptfsm;

  logic       clk, rst, staenc;
  logic [1:0] keysel, keyadsel;
  logic       rndkren, sboxinsel, wrregen, mixsel, reginsel, busy, done;
  logic [3:0] rconsel, enc_state;

  encryptfsm dut (
    .clk(clk), .rst(rst), .staenc(staenc),
    .keysel(keysel), .rndkren(rndkren), .rconsel(rconsel), .sboxinsel(sboxinsel),
    .wrregen(wrregen), .keyadsel(keyadsel), .mixsel(mixsel), .reginsel(reginsel),
    .enc_state(enc_state), .busy(busy), .done(done)
  );

  typedef struct {
    logic [3:0] st;
    logic       dn;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input string what, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s/%s: got %0d, want %0d", tag, what, act, req);
    end
  endtask

  // Monitor: every cycle with a pending expectation is one DUT observation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      int   s;
      e = q.pop_front();
      s = e.st;
      chk(e.tag, "enc_state", enc_state, s);
      chk(e.tag, "done",      done,      e.dn);
      chk(e.tag, "busy",      busy,      (s != 0) ? 1 : 0);
      chk(e.tag, "keysel",    keysel,    (s <= 1) ? 0 : 2);
      chk(e.tag, "rndkren",   rndkren,   (s >= 1 && s <= 10) ? 1 : 0);
      chk(e.tag, "wrregen",   wrregen,   (s >= 1) ? 1 : 0);
      chk(e.tag, "keyadsel",  keyadsel,  (s == 1) ? 1 : (s == 11) ? 2 : 0);
      chk(e.tag, "reginsel",  reginsel,  (s >= 2) ? 1 : 0);
      chk(e.tag, "rconsel",   rconsel,   (s >= 2) ? s - 2 : 0);
      chk(e.tag, "sboxinsel", sboxinsel, 0);
      chk(e.tag, "mixsel",    mixsel,    0);
    end
  end

  // Drive inputs, take one edge, record what must be visible after it.
  task automatic cyc(input logic s, input logic r, input int es, input logic ed, input string tag);
    exp_t e;
    staenc = s;
    rst    = r;
    @(posedge clk);
    e.st = 4'(es);
    e.dn = ed;
    e.tag = tag;
    q.push_back(e);
    #1;
  endtask

  // Finish a block already in state 'from': remaining rounds, done cycle, then idle.
  task automatic tail(input int from, input string tag);
    for (int s = from + 1; s <= 11; s++) cyc(1'b0, 1'b0, s, 1'b0, tag);
    cyc(1'b0, 1'b0, 0, 1'b1, tag);
    cyc(1'b0, 1'b0, 0, 1'b0, tag);
  endtask

  initial begin
    int last;
    rst = 1'b1;
    staenc = 1'b1;

    // reset with staenc asserted: rst wins
    cyc(1'b1, 1'b1, 0, 1'b0, "reset");
    cyc(1'b1, 1'b1, 0, 1'b0, "reset");
    cyc(1'b0, 1'b0, 0, 1'b0, "idle");

    // single block
    cyc(1'b1, 1'b0, 1, 1'b0, "single");
    tail(1, "single");

    // staenc held high for 30 edges
    last = 0;
    for (int k = 0; k < 30; k++) begin
      int p, es;
      logic ed;
`ifdef ENCRYPTFSM_B2B_EN
      p  = k % 11;
      es = p + 1;
      ed = (k >= 11 && p == 0);
`else
      p  = k % 12;
      es = (p < 11) ? p + 1 : 0;
      ed = (p == 11);
`endif
      cyc(1'b1, 1'b0, es, ed, "held");
      last = es;
    end
    tail(last, "held");

    // pulse during ROUND5 is ignored
    cyc(1'b1, 1'b0, 1, 1'b0, "mid_pulse");
    for (int s = 2; s <= 6; s++) cyc(1'b0, 1'b0, s, 1'b0, "mid_pulse");
    cyc(1'b1, 1'b0, 7, 1'b0, "mid_pulse");
    tail(7, "mid_pulse");

    // start request while in ROUND10
    cyc(1'b1, 1'b0, 1, 1'b0, "r10_start");
    for (int s = 2; s <= 11; s++) cyc(1'b0, 1'b0, s, 1'b0, "r10_start");
`ifdef ENCRYPTFSM_B2B_EN
    cyc(1'b1, 1'b0, 1, 1'b1, "r10_start");
    tail(1, "r10_start");
`else
    cyc(1'b1, 1'b0, 0, 1'b1, "r10_start");
    cyc(1'b0, 1'b0, 0, 1'b0, "r10_start");
`endif

    // reset during ROUND6 aborts with no done, then a fresh block runs
    cyc(1'b1, 1'b0, 1, 1'b0, "abort");
    for (int s = 2; s <= 7; s++) cyc(1'b0, 1'b0, s, 1'b0, "abort");
    cyc(1'b0, 1'b1, 0, 1'b0, "abort");
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 0, 1'b0, "abort");
    cyc(1'b1, 1'b0, 1, 1'b0, "restart");
    tail(1, "restart");

    staenc = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    if (n_cmp == 0) begin
      n_bad++;
      $display("FAIL coverage: compared %0d, want >0", n_cmp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
